// File: rtl/instream_source.sv
// ---------------------------------------------------------------------------
// instream_source
//
// Test-harness stimulus source. Replays up to DEPTH preloaded signed words
// into a consumer over a valid/taken handshake. One word is offered at a time.
// After each accepted word there is a one-cycle gap, so the peak rate is one
// word every two cycles. The block also counts cycles in which an offered word
// was not taken (backpressure stalls); that count saturates.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin streaming (honoured only when idle or done)
//   length    in   PW   number of words to send, clamped to DEPTH
//   data      in   WIDTH x [0:DEPTH-1] words to send, read live via pos
//   taken     in   consumer accepts value this edge (only while valid)
//   valid     out  value is being offered
//   value     out  WIDTH word currently or last offered
//   pos       out  PW   index of word being offered / offered next
//   stalls    out  SW   saturating count of valid && !taken cycles
//   busy      out  high while a stream is in progress (OFFER or GAP)
//   complete  out  all requested words delivered
// ---------------------------------------------------------------------------
module instream_source #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 39,
    parameter int PW    = 6,
    parameter int SW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PW-1:0]    length,
    input  logic [WIDTH-1:0] data [0:DEPTH-1],
    input  logic             taken,
    output logic             valid,
    output logic [WIDTH-1:0] value,
    output logic [PW-1:0]    pos,
    output logic [SW-1:0]    stalls,
    output logic             busy,
    output logic             complete
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

    state_t           state_reg,  state_next;
    logic [PW-1:0]    len_reg,    len_next;
    logic [PW-1:0]    pos_reg,    pos_next;
    logic [WIDTH-1:0] value_reg,  value_next;
    logic [SW-1:0]    stalls_reg, stalls_next;

    // Requested length clamped so pos can never index past the data array.
    logic [PW-1:0]    len_clamped;
    logic [PW-1:0]    pos_inc;

    assign len_clamped = (length > DEPTH_W) ? DEPTH_W : length;
    assign pos_inc     = pos_reg + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            len_reg    <= '0;
            pos_reg    <= '0;
            value_reg  <= '0;
            stalls_reg <= '0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            pos_reg    <= pos_next;
            value_reg  <= value_next;
            stalls_reg <= stalls_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        pos_next    = pos_reg;
        value_next  = value_reg;
        stalls_next = stalls_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // A restart from DONE behaves exactly like a start from IDLE.
                if (start) begin
                    len_next    = len_clamped;
                    pos_next    = '0;
                    stalls_next = '0;
                    if (len_clamped == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_OFFER;
                        value_next = data[0];
                    end
                end
            end

            ST_OFFER: begin
                if (taken) begin
                    pos_next   = pos_inc;
                    state_next = (pos_inc == len_reg) ? ST_DONE : ST_GAP;
                end else if (stalls_reg != '1) begin
                    stalls_next = stalls_reg + SW'(1);
                end
            end

            ST_GAP: begin
                // pos already points at the next word; pos < len_reg <= DEPTH here.
                state_next = ST_OFFER;
                value_next = data[pos_reg];
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign valid    = (state_reg == ST_OFFER);
    assign busy     = (state_reg == ST_OFFER) || (state_reg == ST_GAP);
    assign complete = (state_reg == ST_DONE);
    assign value    = value_reg;
    assign pos      = pos_reg;
    assign stalls   = stalls_reg;

endmodule

// File: tb/tb_instream_source.sv
// ---------------------------------------------------------------------------
// tb_instream_source
//
// Directed steps followed by randomized streams. The random streams are
// checked against a handshake-level model: words accepted so far, stall
// cycles seen, and whether the previous cycle completed a transfer.
// ---------------------------------------------------------------------------
module tb_instream_source;

    localparam int WIDTH = 11;
    localparam int DEPTH = 39;
    localparam int PW    = 6;
    localparam int SW    = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [PW-1:0]    length;
    logic [WIDTH-1:0] data [0:DEPTH-1];
    logic             taken;
    logic             valid;
    logic [WIDTH-1:0] value;
    logic [PW-1:0]    pos;
    logic [SW-1:0]    stalls;
    logic             busy;
    logic             complete;

    int checks;
    int failures;

    instream_source #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW), .SW(SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .length   (length),
        .data     (data),
        .taken    (taken),
        .valid    (valid),
        .value    (value),
        .pos      (pos),
        .stalls   (stalls),
        .busy     (busy),
        .complete (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all(input string tag, input int v, input int p, input int s,
                             input int b, input int c);
        check({tag, ".valid"},    int'(valid),    v);
        check({tag, ".pos"},      int'(pos),      p);
        check({tag, ".stalls"},   int'(stalls),   s);
        check({tag, ".busy"},     int'(busy),     b);
        check({tag, ".complete"}, int'(complete), c);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            int sv;
            sv = int'($urandom_range(1998)) - 999;
            data[i] = WIDTH'(sv);
        end
    endtask

    // Run one stream with random backpressure and compare each cycle
    // against the handshake model.
    task automatic run_stream(input int len_req, input int taken_pct);
        int L, acc, st, cyc;
        bit exp_valid;
        bit t;
        L   = (len_req > DEPTH) ? DEPTH : len_req;
        acc = 0;
        st  = 0;
        $display("stream: length=%0d effective=%0d taken_pct=%0d", len_req, L, taken_pct);
        length = PW'(len_req);
        start  = 1'b1;
        taken  = 1'b0;
        tick();
        start = 1'b0;
        exp_valid = (L > 0);
        check("rs.start.valid", int'(valid), int'(exp_valid));
        check("rs.start.complete", int'(complete), int'(L == 0));
        check("rs.start.stalls", int'(stalls), 0);
        if (exp_valid) check("rs.start.value", int'(value), int'(data[0]));
        cyc = 0;
        while (acc < L && cyc < 4000) begin
            t = ($urandom_range(99) < taken_pct);
            taken = t;
            tick();
            cyc++;
            if (exp_valid && t) begin
                acc++;
                exp_valid = 1'b0;
            end else if (exp_valid) begin
                if (st != 65535) st++;
            end else begin
                exp_valid = (acc < L);
            end
            check("rs.valid",    int'(valid),    int'(exp_valid));
            check("rs.pos",      int'(pos),      acc);
            check("rs.stalls",   int'(stalls),   st);
            check("rs.busy",     int'(busy),     int'(acc < L));
            check("rs.complete", int'(complete), int'(acc == L));
            if (exp_valid)    check("rs.value", int'(value), int'(data[acc]));
            else if (acc > 0) check("rs.value_hold", int'(value), int'(data[acc-1]));
        end
        check("rs.budget", int'(acc == L), 1);
        taken = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        length   = PW'(3);
        taken    = 1'b1;
        for (int i = 0; i < DEPTH; i++) data[i] = '0;
        data[0] = WIDTH'(5);
        data[1] = 11'h7F9;   // -7
        data[2] = WIDTH'(999);

        // Reset held with start asserted: everything stays cleared.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("reset", 0, 0, 0, 0, 0);
            check("reset.value", int'(value), 0);
        end
        rst_n = 1'b1;

        // Basic stream, taken held high; start honoured on the first edge.
        begin
            int exp_vals [3];
            exp_vals[0] = 5; exp_vals[1] = 2041; exp_vals[2] = 999;
            for (int k = 0; k < 3; k++) begin
                tick();
                start = 1'b0;
                check("basic.valid_hi", int'(valid), 1);
                check("basic.value", int'(value), exp_vals[k]);
                check("basic.pos", int'(pos), k);
                tick();
                check("basic.valid_lo", int'(valid), 0);
            end
            check_all("basic.end", 0, 3, 0, 0, 1);
            // taken during DONE is ignored.
            tick();
            check_all("done.taken", 0, 3, 0, 0, 1);
        end

        // Backpressure: length 2, four stall cycles per word.
        fill_random();
        length = PW'(2);
        start  = 1'b1;
        taken  = 1'b0;
        tick();
        start = 1'b0;
        check("bp.value0", int'(value), int'(data[0]));
        held = value;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) start = 1'b1;   // start during OFFER must not restart
            tick();
            start = 1'b0;
            check_all("bp.stall0", 1, 0, i, 1, 0);
            check("bp.hold0", int'(value), int'(held));
        end
        taken = 1'b1;
        tick();
        check_all("bp.gap", 0, 1, 4, 1, 0);
        tick();                         // taken=1 in GAP is ignored
        check_all("bp.offer1", 1, 1, 4, 1, 0);
        check("bp.value1", int'(value), int'(data[1]));
        taken = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            tick();
            check_all("bp.stall1", 1, 1, i, 1, 0);
            check("bp.hold1", int'(value), int'(data[1]));
        end
        taken = 1'b1;
        tick();
        check_all("bp.end", 0, 2, 8, 0, 1);
        taken = 1'b0;

        // Restart from DONE with length 1 clears stalls and resends data[0].
        run_stream(1, 100);

        // Zero length: complete on the start edge, valid never rises.
        length = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check_all("zero", 0, 0, 0, 0, 1);
        tick();
        check_all("zero.hold", 0, 0, 0, 0, 1);

        // Oversize length is clamped to DEPTH.
        fill_random();
        run_stream(50, 100);
        check("over.pos", int'(pos), DEPTH);

        // Randomized streams against the model.
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_stream(int'($urandom_range(63)), int'($urandom_range(10, 100)));
        end

        // Asynchronous reset mid-stream at pos=2.
        fill_random();
        length = PW'(5);
        start  = 1'b1;
        taken  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_all("ar.pre", 1, 2, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("ar.now", 0, 0, 0, 0, 0);
        check("ar.value", int'(value), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("ar.idle", 0, 0, 0, 0, 0);
        end
        taken = 1'b0;
        run_stream(3, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
